// File: rtl/jedro_1_ifu_pf_pkg.sv
// Shared definitions for the jedro_1 prefetching instruction fetch unit:
// core-wide defaults and the fetch FSM state encoding.
package jedro_1_ifu_pf_pkg;

  localparam int unsigned JEDRO_1_DATA_WIDTH = 32;
  localparam logic [31:0] JEDRO_1_BOOT_ADDR  = 32'h8000_0000;

  typedef enum logic [1:0] {
    IfuFetch    = 2'd0,
    IfuWaitFull = 2'd1,
    IfuDrain    = 2'd2,
    IfuHalt     = 2'd3
  } ifu_state_e;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return |lsb;
  endfunction

endpackage

// File: rtl/jedro_1_fifo.sv
// Synchronous FIFO with synchronous flush, occupancy count and a head output
// taken straight from the storage registers.
module jedro_1_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];

  always_comb begin
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/jedro_1_ifu_pf.sv
// Prefetching instruction fetch unit: keeps up to FIFO_DEPTH words in flight or
// buffered, handles redirects/flushes and reports fetch exceptions.
module jedro_1_ifu_pf
  import jedro_1_ifu_pf_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH = JEDRO_1_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0]  BOOT_ADDR  = DATA_WIDTH'(JEDRO_1_BOOT_ADDR),
  parameter int unsigned            FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  jmp_instr_i,
  input  logic [DATA_WIDTH-1:0] jmp_address_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] addr_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  exception_ro,
  output logic                  exc_bus_err_ro,
  output logic [DATA_WIDTH-1:0] fault_addr_ro,
  output logic                  ram_stb,
  output logic [DATA_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  input  logic                  ram_ack,
  input  logic                  ram_err
);

  localparam int unsigned EntryW = 2 * DATA_WIDTH + 1;
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;

  ifu_state_e            state_q, state_d;
  logic                  stb_q, stb_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] jmp_tgt_q, jmp_tgt_d;
  logic                  drain_halt_q, drain_halt_d;
  logic                  exc_q, exc_d;
  logic                  bus_err_q, bus_err_d;
  logic [DATA_WIDTH-1:0] fault_q, fault_d;

  logic                  fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [EntryW-1:0]     fifo_wdata, fifo_head;
  logic [CntW-1:0]       fifo_count, cnt_next;

  logic                  resp, resp_ack, jmp_misaligned;
  logic                  head_err;
  logic [DATA_WIDTH-1:0] head_addr, head_data;

  assign resp           = stb_q && (ram_ack || ram_err);
  assign resp_ack       = resp && !ram_err;
  assign jmp_misaligned = is_misaligned(jmp_address_i[1:0]);

  assign head_err  = fifo_head[EntryW-1];
  assign head_addr = fifo_head[2*DATA_WIDTH-1:DATA_WIDTH];
  assign head_data = fifo_head[DATA_WIDTH-1:0];

  // Error entries carry no data; ack+err together counts as err.
  assign fifo_wdata = ram_err ? {1'b1, pc_q, {DATA_WIDTH{1'b0}}} : {1'b0, pc_q, ram_rdata};
  assign cnt_next   = fifo_count + CntW'(fifo_push) - CntW'(fifo_pop);

  jedro_1_fifo #(
    .WIDTH (EntryW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IfuFetch;
      stb_q        <= 1'b0;
      pc_q         <= BOOT_ADDR;
      jmp_tgt_q    <= '0;
      drain_halt_q <= 1'b0;
      exc_q        <= 1'b0;
      bus_err_q    <= 1'b0;
      fault_q      <= '0;
    end else begin
      state_q      <= state_d;
      stb_q        <= stb_d;
      pc_q         <= pc_d;
      jmp_tgt_q    <= jmp_tgt_d;
      drain_halt_q <= drain_halt_d;
      exc_q        <= exc_d;
      bus_err_q    <= bus_err_d;
      fault_q      <= fault_d;
    end
  end

  // Next state. Staying in IfuFetch means a request is issued next cycle, so a
  // free slot must exist once this cycle's push/pop have been applied.
  always_comb begin
    state_d = state_q;
    if (jmp_instr_i) begin
      if (stb_q && !resp)      state_d = IfuDrain;
      else if (jmp_misaligned) state_d = IfuHalt;
      else                     state_d = IfuFetch;
    end else begin
      case (state_q)
        IfuFetch, IfuWaitFull: begin
          if (stb_q && ram_err)                    state_d = IfuHalt;
          else if (stb_q && !ram_ack)              state_d = IfuFetch;
          else if (cnt_next < CntW'(FIFO_DEPTH))   state_d = IfuFetch;
          else                                     state_d = IfuWaitFull;
        end
        IfuDrain: begin
          if (resp) state_d = drain_halt_q ? IfuHalt : IfuFetch;
        end
        default: state_d = IfuHalt;
      endcase
    end
  end

  // Bus request, fetch PC, FIFO control and exception reporting.
  always_comb begin
    stb_d        = (state_d == IfuFetch) || (state_d == IfuDrain);
    pc_d         = pc_q;
    jmp_tgt_d    = jmp_tgt_q;
    drain_halt_d = drain_halt_q;
    exc_d        = 1'b0;
    bus_err_d    = bus_err_q;
    fault_d      = fault_q;
    fifo_flush   = jmp_instr_i;
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;
    if (jmp_instr_i) begin
      jmp_tgt_d    = jmp_address_i;
      drain_halt_d = jmp_misaligned;
      if (state_d == IfuFetch) pc_d = jmp_address_i;
      if (jmp_misaligned) begin
        exc_d     = 1'b1;
        bus_err_d = 1'b0;
        fault_d   = jmp_address_i;
      end
    end else begin
      if (state_q == IfuDrain) begin
        if (resp && !drain_halt_q) pc_d = jmp_tgt_q;
      end else if (resp) begin
        fifo_push = !fifo_full;
        if (resp_ack) pc_d = pc_q + DATA_WIDTH'(4);
      end
      fifo_pop = !fifo_empty && (head_err || ready_i);
      if (!fifo_empty && head_err) begin
        exc_d     = 1'b1;
        bus_err_d = 1'b1;
        fault_d   = head_addr;
      end
    end
  end

  assign valid_o        = !fifo_empty && !head_err;
  assign instr_o        = head_data;
  assign addr_o         = head_addr;
  assign exception_ro   = exc_q;
  assign exc_bus_err_ro = bus_err_q;
  assign fault_addr_ro  = fault_q;
  assign ram_stb        = stb_q;
  assign ram_addr       = pc_q;

endmodule

// File: tb/tb_jedro_1_ifu_pf.sv
// Directed bench for jedro_1_ifu_pf: a vector table for streaming, back-pressure
// and redirects, plus sequences for bus errors, draining and async reset.
module tb_jedro_1_ifu_pf;

  localparam logic [31:0] B   = 32'h8000_0000;
  localparam logic [31:0] KEY = 32'h5A5A_0F0F;
  localparam int          NV  = 25;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        jmp = 1'b0;
  logic        ready = 1'b1;
  logic [31:0] jaddr = '0;
  logic [31:0] instr, addr, fault, raddr, rdata;
  logic        valid, exc, berr, stb, ack, err;

  int          checks = 0;
  int          errors = 0;
  int          waits = 0;
  int          wait_cnt = 0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = '0;
  logic        got;

  typedef struct {
    logic        rdy;
    logic        jmp;
    logic [31:0] ja;
    logic        stb;
    logic [31:0] ra;
    logic        vld;
    logic [31:0] addr;
    logic        exc;
    logic        berr;
    logic [31:0] fault;
  } vec_t;

  vec_t tv [NV];

  always #5 clk = ~clk;

  jedro_1_ifu_pf #(
    .DATA_WIDTH (32),
    .BOOT_ADDR  (B),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .jmp_instr_i    (jmp),
    .jmp_address_i  (jaddr),
    .instr_o        (instr),
    .addr_o         (addr),
    .valid_o        (valid),
    .ready_i        (ready),
    .exception_ro   (exc),
    .exc_bus_err_ro (berr),
    .fault_addr_ro  (fault),
    .ram_stb        (stb),
    .ram_addr       (raddr),
    .ram_rdata      (rdata),
    .ram_ack        (ack),
    .ram_err        (err)
  );

  // Slave: responds after `waits` stalled cycles; data is address ^ KEY.
  always_comb begin
    ack   = 1'b0;
    err   = 1'b0;
    rdata = '0;
    if (stb && wait_cnt >= waits) begin
      if (err_en && raddr == err_addr) err = 1'b1;
      else begin
        ack   = 1'b1;
        rdata = raddr ^ KEY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!stb || ack || err) wait_cnt <= 0;
    else                    wait_cnt <= wait_cnt + 1;
  end

  function automatic vec_t mk(input logic r, input logic j, input logic [31:0] ja,
                              input logic s, input logic [31:0] ra, input logic v,
                              input logic [31:0] a, input logic e, input logic be,
                              input logic [31:0] f);
    vec_t t;
    t.rdy = r; t.jmp = j; t.ja = ja; t.stb = s; t.ra = ra;
    t.vld = v; t.addr = a; t.exc = e; t.berr = be; t.fault = f;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    jmp  = 1'b0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    // Table: zero-wait streaming, redirect, back-pressure, misaligned jump, resume.
    tv[0]  = mk(1'b1, 1'b0, 32'h0,   1'b1, B,          1'b0, 32'h0,      1'b0, 1'b0, 32'h0);
    tv[1]  = mk(1'b1, 1'b0, 32'h0,   1'b1, B + 32'h4,  1'b1, B,          1'b0, 1'b0, 32'h0);
    tv[2]  = mk(1'b1, 1'b0, 32'h0,   1'b1, B + 32'h8,  1'b1, B + 32'h4,  1'b0, 1'b0, 32'h0);
    tv[3]  = mk(1'b1, 1'b0, 32'h0,   1'b1, B + 32'hC,  1'b1, B + 32'h8,  1'b0, 1'b0, 32'h0);
    tv[4]  = mk(1'b1, 1'b1, 32'h100, 1'b1, 32'h100,    1'b0, 32'h0,      1'b0, 1'b0, 32'h0);
    tv[5]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h104,    1'b1, 32'h100,    1'b0, 1'b0, 32'h0);
    tv[6]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h108,    1'b1, 32'h104,    1'b0, 1'b0, 32'h0);
    tv[7]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h10C,    1'b1, 32'h104,    1'b0, 1'b0, 32'h0);
    tv[8]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h110,    1'b1, 32'h104,    1'b0, 1'b0, 32'h0);
    tv[9]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h114,    1'b1, 32'h104,    1'b0, 1'b0, 32'h0);
    tv[10] = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h114,    1'b1, 32'h104,    1'b0, 1'b0, 32'h0);
    tv[11] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h114,    1'b1, 32'h108,    1'b0, 1'b0, 32'h0);
    tv[12] = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h118,    1'b1, 32'h108,    1'b0, 1'b0, 32'h0);
    tv[13] = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h118,    1'b1, 32'h108,    1'b0, 1'b0, 32'h0);
    tv[14] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h118,    1'b1, 32'h10C,    1'b0, 1'b0, 32'h0);
    tv[15] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h11C,    1'b1, 32'h110,    1'b0, 1'b0, 32'h0);
    tv[16] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h120,    1'b1, 32'h114,    1'b0, 1'b0, 32'h0);
    tv[17] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h124,    1'b1, 32'h118,    1'b0, 1'b0, 32'h0);
    tv[18] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h128,    1'b1, 32'h11C,    1'b0, 1'b0, 32'h0);
    tv[19] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h12C,    1'b1, 32'h120,    1'b0, 1'b0, 32'h0);
    tv[20] = mk(1'b1, 1'b1, 32'h102, 1'b0, 32'h12C,    1'b0, 32'h0,      1'b1, 1'b0, 32'h102);
    tv[21] = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h12C,    1'b0, 32'h0,      1'b0, 1'b0, 32'h0);
    tv[22] = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h12C,    1'b0, 32'h0,      1'b0, 1'b0, 32'h0);
    tv[23] = mk(1'b1, 1'b1, 32'h200, 1'b1, 32'h200,    1'b0, 32'h0,      1'b0, 1'b0, 32'h0);
    tv[24] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h204,    1'b1, 32'h200,    1'b0, 1'b0, 32'h0);

    #1 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst stb", stb, 1'b0);
    chk("rst ram_addr", raddr, B);
    chk1("rst valid", valid, 1'b0);
    chk("rst instr", instr, 32'h0);
    chk("rst addr", addr, 32'h0);
    chk1("rst exc", exc, 1'b0);
    chk1("rst berr", berr, 1'b0);
    chk("rst fault", fault, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      ready = tv[i].rdy;
      jmp   = tv[i].jmp;
      jaddr = tv[i].ja;
      step();
      chk1($sformatf("v%0d stb", i), stb, tv[i].stb);
      chk($sformatf("v%0d ram_addr", i), raddr, tv[i].ra);
      chk1($sformatf("v%0d valid", i), valid, tv[i].vld);
      chk1($sformatf("v%0d exc", i), exc, tv[i].exc);
      if (tv[i].vld) begin
        chk($sformatf("v%0d addr", i), addr, tv[i].addr);
        chk($sformatf("v%0d instr", i), instr, tv[i].addr ^ KEY);
      end
      if (tv[i].exc) begin
        chk1($sformatf("v%0d berr", i), berr, tv[i].berr);
        chk($sformatf("v%0d fault", i), fault, tv[i].fault);
      end
    end
    jmp   = 1'b0;
    ready = 1'b1;

    // Redirect while a 3-wait-state request is pending: drain, then refetch.
    waits = 3;
    do_reset();
    step();
    chk("drn first", raddr, B);
    jmp   = 1'b1;
    jaddr = 32'h100;
    step();
    jmp = 1'b0;
    chk1("drn stb hold", stb, 1'b1);
    chk("drn addr hold", raddr, B);
    chk1("drn valid", valid, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      got = ack;
      step();
      if (!got) begin
        chk1("drn stb held", stb, 1'b1);
        chk("drn addr held", raddr, B);
      end
    end
    chk1("drn ack seen", got, 1'b1);
    chk1("drn next stb", stb, 1'b1);
    chk("drn next addr", raddr, 32'h100);
    chk1("drn discarded", valid, 1'b0);
    for (int k = 0; k < 10 && !valid; k++) step();
    chk1("drn first valid", valid, 1'b1);
    chk("drn first addr", addr, 32'h100);
    chk("drn first instr", instr, 32'h100 ^ KEY);

    // Bus error on the third fetch.
    waits    = 0;
    err_en   = 1'b1;
    err_addr = B + 32'h8;
    do_reset();
    step();
    chk("be stb0", raddr, B);
    step();
    chk("be w0", addr, B);
    chk1("be w0 valid", valid, 1'b1);
    step();
    chk("be w1", addr, B + 32'h4);
    chk1("be w1 valid", valid, 1'b1);
    chk("be err addr", raddr, B + 32'h8);
    step();
    chk1("be head valid", valid, 1'b0);
    chk1("be stb off", stb, 1'b0);
    chk1("be exc early", exc, 1'b0);
    step();
    chk1("be exc", exc, 1'b1);
    chk1("be berr", berr, 1'b1);
    chk("be fault", fault, B + 32'h8);
    chk1("be exc valid", valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk1("be halt stb", stb, 1'b0);
      chk1("be exc pulse", exc, 1'b0);
    end
    err_en = 1'b0;
    jmp    = 1'b1;
    jaddr  = 32'h200;
    step();
    jmp = 1'b0;
    chk1("be resume stb", stb, 1'b1);
    chk("be resume addr", raddr, 32'h200);
    step();
    chk("be resume word", addr, 32'h200);

    // Asynchronous reset in the middle of a wait-stated request.
    waits = 3;
    got   = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      step();
      got = stb && !ack;
    end
    chk1("ar pending", got, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk1("ar stb", stb, 1'b0);
    chk("ar ram_addr", raddr, B);
    chk1("ar valid", valid, 1'b0);
    chk("ar instr", instr, 32'h0);
    chk("ar addr", addr, 32'h0);
    chk1("ar berr", berr, 1'b0);
    chk("ar fault", fault, 32'h0);
    waits = 0;
    @(negedge clk);
    rstn = 1'b1;
    step();
    chk1("ar restart stb", stb, 1'b1);
    chk("ar restart addr", raddr, B);
    step();
    chk("ar restart word", addr, B);
    chk("ar restart instr", instr, B ^ KEY);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jedro_1_ifu_pf.md
# jedro_1_ifu_pf

Parametrised prefetching instruction fetch unit for the jedro_1 core. It replaces the single-word fetch path with a configurable-depth prefetch FIFO. Fetches run over a stb/ack/err bus, the same bus style the data port uses. Instruction words are handed to the decoder with a valid/ready handshake. Jumps and traps flush the unit, and misaligned targets and bus errors are reported to the CSR unit.

## Interface
- DATA_WIDTH, 32, instruction/address width.
- BOOT_ADDR, `JEDRO_1_BOOT_ADDR, first fetch address after reset.
- FIFO_DEPTH, 4, prefetch entries. Power of two, at least 2.

- clk_i  in  1  core clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- jmp_instr_i  in  1  redirect request (jump, branch, trap, mret).
- jmp_address_i  in  DATA_WIDTH  redirect target.
- instr_o  out  DATA_WIDTH  head instruction word.
- addr_o  out  DATA_WIDTH  address of the head instruction.
- valid_o  out  1  head entry is a valid instruction.
- ready_i  in  1  decoder accepts the head entry.
- exception_ro  out  1  one-cycle fetch exception pulse.
- exc_bus_err_ro  out  1  qualifies exception_ro: 1 = access fault, 0 = misaligned target.
- fault_addr_ro  out  DATA_WIDTH  faulting address, held until the next exception.
- ram_stb  out  1  fetch request.
- ram_addr  out  DATA_WIDTH  fetch address, word aligned.
- ram_rdata  in  DATA_WIDTH  fetched word.
- ram_ack  in  1  request completed, ram_rdata valid.
- ram_err  in  1  request failed.

## Operation
- Reset values:
  - ram_stb=0, ram_addr=BOOT_ADDR.
  - valid_o=0, instr_o=0, addr_o=0.
  - exception_ro=0, exc_bus_err_ro=0, fault_addr_ro=0.
  - FIFO empty, no request pending.
- State machine:
  - FETCH: issue requests while the free slots are greater than zero. Free slots = FIFO_DEPTH − count − pending.
  - WAIT_FULL: no slot free, ram_stb=0.
  - DRAIN: a redirect arrived while a request was pending. Hold ram_stb and ram_addr until ack or err, discard the response, then go to FETCH at the redirect target.
  - HALT: entered after an exception. No requests issued. Left only on jmp_instr_i.
- Bus rules:
  - At most one outstanding request.
  - ram_stb and ram_addr stay stable until ram_ack or ram_err is sampled high.
  - ram_ack and ram_err together are treated as err.
  - After ack, the next word (PC+4) may be requested in the following cycle. ram_stb may stay high back-to-back.
- Accepted ack: push {ram_addr, ram_rdata, err=0} into the FIFO and increment the fetch PC by 4. The PC wraps modulo 2^DATA_WIDTH.
- Accepted err: push {ram_addr, err=1}, then go to HALT.
- FIFO head handling:
  - Clean head entry: valid_o=1.
  - Pop when valid_o && ready_i.
  - Error head entry: valid_o=0, exception_ro=1 for one cycle, exc_bus_err_ro=1, fault_addr_ro=entry address. The entry is then dropped.
- Redirect (jmp_instr_i=1):
  - Flush the FIFO; a pop in the same cycle is ignored.
  - If jmp_address_i[1:0]≠0: exception_ro=1 and exc_bus_err_ro=0 in the next cycle, fault_addr_ro=jmp_address_i, go to HALT.
  - Otherwise the fetch PC becomes jmp_address_i.
- Redirect in the same cycle as ack or err: the response is discarded and the redirect wins.
- Redirect while in HALT clears HALT.
- Reset mid-transaction: all state clears immediately. The bus slave must tolerate ram_stb dropping.

## Timing
- First ram_stb=1 (addr BOOT_ADDR) in the first cycle after rstn_i rises.
- Zero-wait ack: the word is visible on instr_o/valid_o in the cycle after ack. Sustained throughput is 1 instruction/cycle.
- Redirect with no request pending: valid_o=0 and ram_stb=1 at the target in the next cycle. The target's first word reaches valid_o no sooner than 2 cycles after the redirect.
- Full FIFO: ram_stb deasserts in the cycle the last slot is reserved. It reasserts in the cycle after a pop frees a slot.
- exception_ro never coincides with valid_o=1.

## Structure
- jedro_1_defines.v keeps DATA_WIDTH and JEDRO_1_BOOT_ADDR. Add IFU state encodings: IFU_FETCH, IFU_WAIT_FULL, IFU_DRAIN, IFU_HALT.
- Sub-module jedro_1_fifo:
  - Synchronous FIFO, parametrised WIDTH and DEPTH.
  - Ports: push, pop, synchronous flush, count, full, empty, registered head output.
  - Entry width = 2·DATA_WIDTH+1.
- The top level holds the FSM, fetch PC, slot accounting and exception logic.

## Test plan
- Reset release with a zero-wait slave returning word i at address 0x8000_0000+4i → stb at 0x8000_0000 in cycle 1; instr_o/addr_o stream consecutive words at 1 per cycle with ready_i=1.
- ready_i=0 with FIFO_DEPTH=4 → exactly 4 words buffered and ram_stb low. Raising ready_i for 1 cycle → exactly one new request issued.
- Slave with 3 wait states; jmp_instr_i to 0x100 while a request is pending → stb and addr held until ack, response discarded, next request at 0x100, first valid_o shows addr_o=0x100.
- ram_err on the fetch at 0x8000_0008 → 2 clean words delivered, then exception_ro pulse with exc_bus_err_ro=1 and fault_addr_ro=0x8000_0008. No further stb until a jump.
- jmp_instr_i to 0x102 → exception_ro=1, exc_bus_err_ro=0, fault_addr_ro=0x102, no fetch. A following jump to 0x200 resumes fetching.
- rstn_i asserted low mid-wait-state → all outputs at reset values asynchronously. Fetch restarts at BOOT_ADDR.
